nyancat_anim_ctrl: RTL

Animation sequencer for the Nyancat renderer: owns the frame index that selects the 4096-entry slice of frame ROM and advances it only on a vertical-blank tick, so a frame change never tears mid-screen. A control source (UART/button debouncer/host CPU) drives a valid/ready command port for play, pause, single-step, seek and speed changes. The block sits between the VGA sync generator and the renderer's frame-index input, replacing the free-running clock-count sequencer.

---
 rtl/nyancat_anim_ctrl.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/nyancat_anim_ctrl.sv
// nyancat_anim_ctrl: animation frame sequencer for the Nyancat renderer.
// Holds the frame index and only loads it on a vertical-blank tick, so the
// displayed frame never changes mid-screen. Commands arrive on a valid/ready
// port (PLAY, PAUSE, STEP, SET_DIV, SEEK, DIR).
// Optional feature: define NYANCAT_ANIM_REVERSE_EN to enable the DIR command
// (reverse playback). Without it DIR is a no-op and playback is forward only.
module nyancat_anim_ctrl #(
  parameter  int NUM_FRAMES  = 12,
  parameter  int ARG_W       = 4,
  parameter  int DEFAULT_DIV = 6,
  // IDX_W must not exceed ARG_W: SEEK loads the index from the argument.
  localparam int IDX_W       = $clog2(NUM_FRAMES)
) (
  input  logic             px_clk,
  input  logic             reset_n,
  input  logic             vblank_tick,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [ARG_W-1:0] cmd_arg,
  output logic [IDX_W-1:0] frame_index,
  output logic             frame_adv,
  output logic             playing
);

  // Run states
  localparam logic [1:0] ST_PLAYING   = 2'd0;
  localparam logic [1:0] ST_PAUSED    = 2'd1;
  localparam logic [1:0] ST_STEP_PEND = 2'd2;
  localparam logic [1:0] ST_SEEK_PEND = 2'd3;

  // Command opcodes (7 is reserved and behaves as NOP)
  localparam logic [2:0] OP_NOP     = 3'd0;
  localparam logic [2:0] OP_PLAY    = 3'd1;
  localparam logic [2:0] OP_PAUSE   = 3'd2;
  localparam logic [2:0] OP_STEP    = 3'd3;
  localparam logic [2:0] OP_SET_DIV = 3'd4;
  localparam logic [2:0] OP_SEEK    = 3'd5;
  localparam logic [2:0] OP_DIR     = 3'd6;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_FRAMES - 1);
  localparam logic [ARG_W-1:0] LAST_ARG = ARG_W'(NUM_FRAMES - 1);

  logic [1:0]       r_state;
  logic [IDX_W-1:0] r_frame_index;
  logic             r_frame_adv;
  logic [ARG_W-1:0] r_div;
  logic [ARG_W-1:0] r_div_cnt;
  logic [IDX_W-1:0] r_pend_idx;
  logic             r_resume;

  logic [1:0]       w_state_next;
  logic [IDX_W-1:0] w_index_next;
  logic             w_adv_next;
  logic [ARG_W-1:0] w_div_next;
  logic [ARG_W-1:0] w_div_cnt_next;
  logic [IDX_W-1:0] w_pend_idx_next;
  logic             w_resume_next;
  logic [IDX_W-1:0] w_index_adv;
  logic             w_cmd_fire;

`ifdef NYANCAT_ANIM_REVERSE_EN
  logic r_dir;
  logic w_dir_next;

  // Next frame in the current direction, wrapping at both ends
  assign w_index_adv = r_dir
    ? ((r_frame_index == '0) ? LAST_IDX : r_frame_index - IDX_W'(1))
    : ((r_frame_index == LAST_IDX) ? '0 : r_frame_index + IDX_W'(1));
`else
  // Next frame, forward only, wrapping to frame 0
  assign w_index_adv = (r_frame_index == LAST_IDX) ? '0 : r_frame_index + IDX_W'(1);
`endif

  assign cmd_ready   = (r_state == ST_PLAYING) || (r_state == ST_PAUSED);
  assign w_cmd_fire  = cmd_valid && cmd_ready;
  assign playing     = (r_state == ST_PLAYING) || ((r_state == ST_SEEK_PEND) && r_resume);
  assign frame_index = r_frame_index;
  assign frame_adv   = r_frame_adv;

  // Next-state: the tick acts on pre-command state, then an accepted command
  // overwrites whatever registers it writes (e.g. PLAY clearing div_cnt).
  always_comb begin
    w_state_next    = r_state;
    w_index_next    = r_frame_index;
    w_adv_next      = 1'b0;
    w_div_next      = r_div;
    w_div_cnt_next  = r_div_cnt;
    w_pend_idx_next = r_pend_idx;
    w_resume_next   = r_resume;
`ifdef NYANCAT_ANIM_REVERSE_EN
    w_dir_next      = r_dir;
`endif

    if (vblank_tick) begin
      case (r_state)
        ST_PLAYING: begin
          if (r_div_cnt == r_div - ARG_W'(1)) begin
            w_index_next   = w_index_adv;
            w_adv_next     = 1'b1;
            w_div_cnt_next = '0;
          end else begin
            w_div_cnt_next = r_div_cnt + ARG_W'(1);
          end
        end
        ST_STEP_PEND: begin
          w_index_next = w_index_adv;
          w_adv_next   = 1'b1;
          w_state_next = ST_PAUSED;
        end
        ST_SEEK_PEND: begin
          w_index_next   = r_pend_idx;
          w_adv_next     = 1'b1;
          w_div_cnt_next = '0;
          w_state_next   = r_resume ? ST_PLAYING : ST_PAUSED;
        end
        default: ;
      endcase
    end

    if (w_cmd_fire) begin
      case (cmd_op)
        OP_NOP: ;
        OP_PLAY: begin
          w_state_next   = ST_PLAYING;
          w_div_cnt_next = '0;
        end
        OP_PAUSE: w_state_next = ST_PAUSED;
        OP_STEP: begin
          // Single-step only makes sense while paused
          if (r_state == ST_PAUSED) w_state_next = ST_STEP_PEND;
        end
        OP_SET_DIV: begin
          w_div_next     = (cmd_arg == '0) ? ARG_W'(1) : cmd_arg;
          w_div_cnt_next = '0;
        end
        OP_SEEK: begin
          w_pend_idx_next = (cmd_arg > LAST_ARG) ? LAST_IDX : cmd_arg[IDX_W-1:0];
          w_resume_next   = (r_state == ST_PLAYING);
          w_state_next    = ST_SEEK_PEND;
        end
`ifdef NYANCAT_ANIM_REVERSE_EN
        OP_DIR: w_dir_next = cmd_arg[0];
`else
        OP_DIR: ;
`endif
        default: ;
      endcase
    end
  end

  // State and datapath registers, cleared asynchronously on reset
  always_ff @(posedge px_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= ST_PLAYING;
      r_frame_index <= '0;
      r_frame_adv   <= 1'b0;
      r_div         <= ARG_W'(DEFAULT_DIV);
      r_div_cnt     <= '0;
      r_pend_idx    <= '0;
      r_resume      <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_frame_index <= w_index_next;
      r_frame_adv   <= w_adv_next;
      r_div         <= w_div_next;
      r_div_cnt     <= w_div_cnt_next;
      r_pend_idx    <= w_pend_idx_next;
      r_resume      <= w_resume_next;
    end
  end

`ifdef NYANCAT_ANIM_REVERSE_EN
  // Playback direction, forward after reset
  always_ff @(posedge px_clk or negedge reset_n) begin
    if (!reset_n) r_dir <= 1'b0;
    else          r_dir <= w_dir_next;
  end
`endif

endmodule
